// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// carry-majority helper used by the full-adder cell.
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  function automatic logic majority(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_bit.sv
// Purely combinational 1-bit full adder; the only arithmetic cell of the
// serial adder, reused once per bit.
module fa_bit
  import serial_adder_ctrl_pkg::*;
(
  input  logic A,
  input  logic B,
  input  logic Ci,
  output logic S,
  output logic Co
);

  assign S  = A ^ B ^ Ci;
  assign Co = majority(A, B, Ci);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell walks the operands LSB
// first over WIDTH cycles, then pulses Done with {Cout, Sum}.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [WIDTH-1:0] DataA,
  input  logic [WIDTH-1:0] DataB,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  state_t             state_r;
  state_t             next_state_s;
  logic [WIDTH-1:0]   sh_a_r;
  logic [WIDTH-1:0]   sh_b_r;
  logic [WIDTH-1:0]   sum_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               carry_r;
  logic               cout_r;
  logic               busy_r;
  logic               done_r;
  logic               busy_nxt_s;
  logic               done_nxt_s;
  logic               last_bit_s;
  logic               fa_s;
  logic               fa_co;

  assign last_bit_s = (cnt_r == CNT_W'(WIDTH - 1));

  fa_bit u_fa (
    .A  (sh_a_r[0]),
    .B  (sh_b_r[0]),
    .Ci (carry_r),
    .S  (fa_s),
    .Co (fa_co)
  );

  // State register; an illegal encoding falls back to IDLE via next-state logic.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (Start) begin
          next_state_s = ST_SHIFT;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_bit_s) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_SHIFT;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so Busy/Done can be registered.
  always_comb begin
    busy_nxt_s = 1'b0;
    done_nxt_s = 1'b0;
    case (next_state_s)
      ST_IDLE: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
      ST_SHIFT: begin
        busy_nxt_s = 1'b1;
        done_nxt_s = 1'b0;
      end
      ST_DONE: begin
        busy_nxt_s = 1'b1;
        done_nxt_s = 1'b1;
      end
      default: begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture, serial shift, carry, counter, result and flags.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sh_a_r  <= '0;
      sh_b_r  <= '0;
      sum_r   <= '0;
      cnt_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
      case (state_r)
        ST_IDLE: begin
          if (Start) begin
            sh_a_r  <= DataA;
            sh_b_r  <= DataB;
            carry_r <= Cin;
            cnt_r   <= '0;
          end
        end
        ST_SHIFT: begin
          sum_r   <= {fa_s, sum_r[WIDTH-1:1]};
          carry_r <= fa_co;
          sh_a_r  <= {1'b0, sh_a_r[WIDTH-1:1]};
          sh_b_r  <= {1'b0, sh_b_r[WIDTH-1:1]};
          cnt_r   <= cnt_r + CNT_W'(1);
          // Cout only moves on the final bit so it holds between operations.
          if (last_bit_s) begin
            cout_r <= fa_co;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign Busy = busy_r;
  assign Done = done_r;
  assign Sum  = sum_r;
  assign Cout = cout_r;

endmodule
